// File: rtl/mem_ctrl_pkg.sv
// Shared types, widths and the parity helper for the memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int MEM_W  = DATA_W + 1;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Even parity: the MSB must equal the XOR of the data bits.
  function automatic logic parity_ok(input logic [MEM_W-1:0] word);
    return word[MEM_W-1] == (^word[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Request sequencer for the 9-bit parity memory: one-cycle write/read strobes,
// registered capture of read data with parity check, saturating error counter.
module mem_access_ctrl #(
  parameter int ADDR_W   = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W   = mem_ctrl_pkg::DATA_W,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_parity_err,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W:0]     mem_data_out,
  output logic [ERRCNT_W-1:0] err_count
);

  import mem_ctrl_pkg::*;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_req_ready;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_data_in;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_parity_err;
  logic [ERRCNT_W-1:0] r_err_count;
  logic                w_accept;
  logic                w_parity_bad;

  // The package helper is sized for the default width; other widths use the
  // same even-parity rule written out directly.
  generate
    if (DATA_W == mem_ctrl_pkg::DATA_W) begin : g_par_pkg
      assign w_parity_bad = !parity_ok(mem_data_out);
    end else begin : g_par_gen
      assign w_parity_bad = (^mem_data_out[DATA_W-1:0]) != mem_data_out[DATA_W];
    end
  endgenerate

  // req_ready is a register so it can be low throughout reset and still
  // have no combinational path from any input.
  assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;

  // State register and ready flag; ready is set whenever the next state is IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == IDLE);
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = req_write ? WRITE : READ;
        end
      end
      WRITE:   w_state_next = IDLE;
      READ:    w_state_next = CAPTURE;
      CAPTURE: w_state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address/data latch on accept; held between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else if (w_accept) begin
      r_mem_address <= req_addr;
      r_mem_data_in <= req_wdata;
    end
  end

  // Capture read word and parity result; held stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata      <= '0;
      r_rsp_parity_err <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_rsp_rdata      <= mem_data_out[DATA_W-1:0];
      r_rsp_parity_err <= w_parity_bad;
    end
  end

  // Saturating parity-error counter, bumped once per failing capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if ((r_state == CAPTURE) && w_parity_bad && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign req_ready      = r_req_ready;
  assign mem_write      = (r_state == WRITE);
  assign mem_read       = (r_state == READ);
  assign mem_address    = r_mem_address;
  assign mem_data_in    = r_mem_data_in;
  assign rsp_valid      = (r_state == RESP);
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_parity_err = r_rsp_parity_err;
  assign err_count      = r_err_count;

endmodule
